eth_tx_arbiter: RTL and testbench

ETH_TX_ARBITER -- requirements
Module: eth_tx_arbiter

---
 rtl/eth_tx_arbiter_pkg.sv | 18 +
 rtl/eth_tx_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_eth_tx_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/eth_tx_arbiter_pkg.sv
// Shared definitions for the two-requester Ethernet TX arbiter.
//   state_e            : arbiter FSM states
//   DefaultMaxFrameLen : default frame length limit in bytes (forced last byte included)
//   Req0 / Req1        : requester index values used by the round-robin pointer
package eth_tx_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StPass,
        StDrain
    } state_e;

    localparam int unsigned DefaultMaxFrameLen = 1522;

    localparam logic Req0 = 1'b0;
    localparam logic Req1 = 1'b1;

endpackage

// File: rtl/eth_tx_arbiter.sv
// Two-input round-robin frame arbiter in front of a MAC TX AXI-Stream port.
// A whole frame from the granted requester is passed through combinationally;
// frames longer than MAX_FRAME_LEN are cut (last beat flagged with tlast=1,
// tuser=1) and the remainder of the source frame is silently drained.
//
// Ports
//   clock125            : single clock, all ports synchronous to it
//   reset               : synchronous, active-high
//   s0_axis_* / s1_axis_*: requester AXI-Stream slaves (8-bit data, 1-bit keep/user)
//   m_axis_*            : AXI-Stream master toward the MAC
//   grant               : one-hot current owner, 00 while idle
//   frames_sent         : frames completed on m_axis (wraps)
//   frames_truncated    : frames cut at MAX_FRAME_LEN (wraps)
module eth_tx_arbiter
    import eth_tx_arbiter_pkg::*;
#(
    parameter int unsigned MAX_FRAME_LEN = DefaultMaxFrameLen,
    parameter int unsigned CNT_WIDTH     = 16
) (
    input  logic                 clock125,
    input  logic                 reset,

    input  logic [7:0]           s0_axis_tdata,
    input  logic                 s0_axis_tkeep,
    input  logic                 s0_axis_tvalid,
    output logic                 s0_axis_tready,
    input  logic                 s0_axis_tlast,
    input  logic                 s0_axis_tuser,

    input  logic [7:0]           s1_axis_tdata,
    input  logic                 s1_axis_tkeep,
    input  logic                 s1_axis_tvalid,
    output logic                 s1_axis_tready,
    input  logic                 s1_axis_tlast,
    input  logic                 s1_axis_tuser,

    output logic [7:0]           m_axis_tdata,
    output logic                 m_axis_tkeep,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 m_axis_tlast,
    output logic                 m_axis_tuser,

    output logic [1:0]           grant,
    output logic [CNT_WIDTH-1:0] frames_sent,
    output logic [CNT_WIDTH-1:0] frames_truncated
);

    localparam int unsigned LenW = $clog2(MAX_FRAME_LEN + 1);
    // Counter value while the MAX_FRAME_LEN-th byte is on the bus.
    localparam logic [LenW-1:0] LimitIdx = LenW'(MAX_FRAME_LEN - 1);

    state_e               state_q, state_d;
    logic [1:0]           grant_q, grant_d;
    logic                 ptr_q, ptr_d;
    logic [LenW-1:0]      byte_cnt_q, byte_cnt_d;
    logic [CNT_WIDTH-1:0] sent_q, sent_d;
    logic [CNT_WIDTH-1:0] trunc_q, trunc_d;

    logic       owner;
    logic [7:0] src_tdata;
    logic       src_tkeep;
    logic       src_tvalid;
    logic       src_tlast;
    logic       src_tuser;
    logic       m_hs;
    logic       at_limit;
    logic       trunc_beat;
    logic       pick;

    assign owner = grant_q[1];

    // Selected source, keyed off the registered grant so it cannot move mid-frame.
    always_comb begin
        if (owner == Req1) begin
            src_tdata  = s1_axis_tdata;
            src_tkeep  = s1_axis_tkeep;
            src_tvalid = s1_axis_tvalid;
            src_tlast  = s1_axis_tlast;
            src_tuser  = s1_axis_tuser;
        end else begin
            src_tdata  = s0_axis_tdata;
            src_tkeep  = s0_axis_tkeep;
            src_tvalid = s0_axis_tvalid;
            src_tlast  = s0_axis_tlast;
            src_tuser  = s0_axis_tuser;
        end
    end

    assign m_hs       = (state_q == StPass) && src_tvalid && m_axis_tready;
    assign at_limit   = (byte_cnt_q == LimitIdx);
    // A source tlast on the limit beat is a normal end, not a truncation.
    assign trunc_beat = at_limit && !src_tlast;

    // State register
    always_ff @(posedge clock125) begin
        if (reset) begin
            state_q    <= StIdle;
            grant_q    <= 2'b00;
            ptr_q      <= Req0;
            byte_cnt_q <= '0;
            sent_q     <= '0;
            trunc_q    <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            ptr_q      <= ptr_d;
            byte_cnt_q <= byte_cnt_d;
            sent_q     <= sent_d;
            trunc_q    <= trunc_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        ptr_d      = ptr_q;
        byte_cnt_d = byte_cnt_q;
        sent_d     = sent_q;
        trunc_d    = trunc_q;
        pick       = Req0;

        case (state_q)
            StIdle: begin
                if (s0_axis_tvalid || s1_axis_tvalid) begin
                    if (s0_axis_tvalid && s1_axis_tvalid) begin
                        pick = ptr_q;
                    end else begin
                        pick = s1_axis_tvalid ? Req1 : Req0;
                    end
                    grant_d    = (pick == Req1) ? 2'b10 : 2'b01;
                    byte_cnt_d = '0;
                    state_d    = StPass;
                end
            end

            StPass: begin
                if (m_hs) begin
                    byte_cnt_d = byte_cnt_q + LenW'(1);
                    if (src_tlast) begin
                        state_d = StIdle;
                        grant_d = 2'b00;
                        sent_d  = sent_q + CNT_WIDTH'(1);
                        // Hand preference to the requester that did not just send.
                        ptr_d   = (owner == Req1) ? Req0 : Req1;
                    end else if (at_limit) begin
                        state_d = StDrain;
                        sent_d  = sent_q + CNT_WIDTH'(1);
                        trunc_d = trunc_q + CNT_WIDTH'(1);
                    end
                end
            end

            StDrain: begin
                // Source tready is forced high here, so tvalid alone is a handshake.
                if (src_tvalid && src_tlast) begin
                    state_d = StIdle;
                    grant_d = 2'b00;
                    ptr_d   = (owner == Req1) ? Req0 : Req1;
                end
            end

            default: begin
                state_d = StIdle;
                grant_d = 2'b00;
            end
        endcase
    end

    // Output logic
    always_comb begin
        s0_axis_tready = 1'b0;
        s1_axis_tready = 1'b0;
        m_axis_tdata   = 8'h00;
        m_axis_tkeep   = 1'b0;
        m_axis_tvalid  = 1'b0;
        m_axis_tlast   = 1'b0;
        m_axis_tuser   = 1'b0;

        case (state_q)
            StPass: begin
                m_axis_tdata  = src_tdata;
                m_axis_tkeep  = src_tkeep;
                m_axis_tvalid = src_tvalid;
                m_axis_tlast  = src_tlast || trunc_beat;
                m_axis_tuser  = src_tuser || trunc_beat;
                if (owner == Req1) begin
                    s1_axis_tready = m_axis_tready;
                end else begin
                    s0_axis_tready = m_axis_tready;
                end
            end

            StDrain: begin
                if (owner == Req1) begin
                    s1_axis_tready = 1'b1;
                end else begin
                    s0_axis_tready = 1'b1;
                end
            end

            default: ;
        endcase
    end

    assign grant            = grant_q;
    assign frames_sent      = sent_q;
    assign frames_truncated = trunc_q;

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Scoreboard bench for eth_tx_arbiter (MAX_FRAME_LEN = 100).
module tb_eth_tx_arbiter;

    localparam int unsigned MaxLen = 100;
    localparam int unsigned CntW   = 16;

    typedef struct packed {
        logic [7:0] data;
        logic       keep;
        logic       last;
        logic       user;
    } beat_t;

    logic clock125 = 1'b0;
    logic reset    = 1'b1;

    logic [7:0] s0_data  = 8'h00;
    logic       s0_keep  = 1'b0;
    logic       s0_valid = 1'b0;
    logic       s0_last  = 1'b0;
    logic       s0_user  = 1'b0;
    wire        s0_ready;
    logic [7:0] s1_data  = 8'h00;
    logic       s1_keep  = 1'b0;
    logic       s1_valid = 1'b0;
    logic       s1_last  = 1'b0;
    logic       s1_user  = 1'b0;
    wire        s1_ready;

    wire [7:0]      m_data;
    wire            m_keep;
    wire            m_valid;
    wire            m_last;
    wire            m_user;
    logic           m_ready = 1'b1;
    wire [1:0]      grant;
    wire [CntW-1:0] frames_sent;
    wire [CntW-1:0] frames_truncated;

    eth_tx_arbiter #(
        .MAX_FRAME_LEN (MaxLen),
        .CNT_WIDTH     (CntW)
    ) dut (
        .clock125         (clock125),
        .reset            (reset),
        .s0_axis_tdata    (s0_data),
        .s0_axis_tkeep    (s0_keep),
        .s0_axis_tvalid   (s0_valid),
        .s0_axis_tready   (s0_ready),
        .s0_axis_tlast    (s0_last),
        .s0_axis_tuser    (s0_user),
        .s1_axis_tdata    (s1_data),
        .s1_axis_tkeep    (s1_keep),
        .s1_axis_tvalid   (s1_valid),
        .s1_axis_tready   (s1_ready),
        .s1_axis_tlast    (s1_last),
        .s1_axis_tuser    (s1_user),
        .m_axis_tdata     (m_data),
        .m_axis_tkeep     (m_keep),
        .m_axis_tvalid    (m_valid),
        .m_axis_tready    (m_ready),
        .m_axis_tlast     (m_last),
        .m_axis_tuser     (m_user),
        .grant            (grant),
        .frames_sent      (frames_sent),
        .frames_truncated (frames_truncated)
    );

    always #4 clock125 = ~clock125;

    // Stimulus queues (source side) and expected output beats per requester.
    beat_t      src0[$];
    beat_t      src1[$];
    beat_t      exp0[$];
    beat_t      exp1[$];
    logic [1:0] grant_log[$];

    int   tests = 0;
    int   fails = 0;
    int   model_sent = 0;
    int   model_trunc = 0;
    int   beat_cnt = 0;
    bit   bubbles = 1'b0;
    bit   rand_ready = 1'b0;

    logic [1:0] prev_grant = 2'b00;
    logic [1:0] rr_exp = 2'b00;
    bit         rr_pending = 1'b0;
    logic       model_ptr = 1'b0;
    logic       acc0, acc1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Queue one source frame and its expected appearance on m_axis.
    task automatic send_frame(input int src, input int len, input bit rand_user);
        beat_t b;
        beat_t e;
        for (int i = 0; i < len; i++) begin
            b.data = 8'($urandom);
            b.keep = 1'($urandom);
            b.user = rand_user ? 1'($urandom) : 1'b0;
            b.last = (i == len - 1);
            if (src == 1) src1.push_back(b); else src0.push_back(b);
            if (i < int'(MaxLen)) begin
                e = b;
                if (len > int'(MaxLen) && i == int'(MaxLen) - 1) begin
                    e.last = 1'b1;
                    e.user = 1'b1;
                end
                if (src == 1) exp1.push_back(e); else exp0.push_back(e);
            end
        end
        model_sent++;
        if (len > int'(MaxLen)) model_trunc++;
    endtask

    task automatic wait_done(input int budget, input string name);
        int n = 0;
        while (!(src0.size() == 0 && src1.size() == 0 && exp0.size() == 0 &&
                 exp1.size() == 0 && grant == 2'b00 && !s0_valid && !s1_valid) &&
               n < budget) begin
            @(negedge clock125);
            #2;
            n++;
        end
        check(name, 32'(n >= budget), 32'd0);
    endtask

    task automatic check_counts(input string name);
        check({name, "_sent"}, 32'(frames_sent), 32'(model_sent));
        check({name, "_trunc"}, 32'(frames_truncated), 32'(model_trunc));
    endtask

    task automatic do_reset();
        @(negedge clock125);
        #2;
        reset = 1'b1;
        @(posedge clock125);
        @(negedge clock125);
        #2;
        reset = 1'b0;
        model_sent  = 0;
        model_trunc = 0;
    endtask

    // Source and sink driver: AXI rules, tvalid held until accepted.
    initial begin
        forever begin
            @(negedge clock125);
            acc0 = s0_valid && s0_ready;
            acc1 = s1_valid && s1_ready;
            @(posedge clock125);
            #1;
            if (reset) begin
                src0.delete();
                src1.delete();
                s0_valid = 1'b0;
                s1_valid = 1'b0;
            end else begin
                if (acc0 && src0.size() > 0) void'(src0.pop_front());
                if (acc1 && src1.size() > 0) void'(src1.pop_front());
                if (acc0 || !s0_valid) begin
                    if (src0.size() > 0 && !(bubbles && $urandom_range(0, 3) == 0)) begin
                        s0_valid = 1'b1;
                        {s0_data, s0_keep, s0_last, s0_user} = src0[0];
                    end else begin
                        s0_valid = 1'b0;
                    end
                end
                if (acc1 || !s1_valid) begin
                    if (src1.size() > 0 && !(bubbles && $urandom_range(0, 3) == 0)) begin
                        s1_valid = 1'b1;
                        {s1_data, s1_keep, s1_last, s1_user} = src1[0];
                    end else begin
                        s1_valid = 1'b0;
                    end
                end
            end
            m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic monitor_step();
        logic  own;
        logic  ov, ordy, olast;
        beat_t got;
        beat_t want;
        if (rr_pending) begin
            check("rr_grant", 32'(grant), 32'(rr_exp));
            rr_pending = 1'b0;
        end
        if (grant == 2'b00) begin
            check("idle_outputs", {29'd0, m_valid, s0_ready, s1_ready}, 32'd0);
            if (s0_valid || s1_valid) begin
                rr_pending = 1'b1;
                if (s0_valid && s1_valid) rr_exp = model_ptr ? 2'b10 : 2'b01;
                else rr_exp = s1_valid ? 2'b10 : 2'b01;
            end
        end else begin
            if (prev_grant != 2'b00) check("grant_hold", 32'(grant), 32'(prev_grant));
            else grant_log.push_back(grant);
            own   = grant[1];
            ov    = own ? s1_valid : s0_valid;
            ordy  = own ? s1_ready : s0_ready;
            olast = own ? s1_last : s0_last;
            if (m_valid) begin
                if (m_ready) begin
                    got = {m_data, m_keep, m_last, m_user};
                    beat_cnt++;
                    if ((own && exp1.size() == 0) || (!own && exp0.size() == 0)) begin
                        tests++;
                        fails++;
                        $display("FAIL extra_beat: got %h from requester %0d, expected none",
                                 got, own);
                    end else begin
                        if (own) want = exp1.pop_front(); else want = exp0.pop_front();
                        check("beat", 32'(got), 32'(want));
                    end
                end else begin
                    check("stall", 32'(ordy), 32'd0);
                end
            end
            // A completed source frame hands preference to the other requester.
            if (ov && ordy && olast) model_ptr = ~own;
        end
        prev_grant = grant;
    endtask

    initial begin
        forever begin
            @(negedge clock125);
            if (reset) begin
                prev_grant = 2'b00;
                rr_pending = 1'b0;
                model_ptr  = 1'b0;
            end else begin
                monitor_step();
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] seq [4];
        int         base;
        int         n;
        seq[0] = 2'b01;
        seq[1] = 2'b10;
        seq[2] = 2'b01;
        seq[3] = 2'b10;

        repeat (3) @(posedge clock125);
        @(negedge clock125);
        #2;
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_sent", 32'(frames_sent), 32'd0);
        check("rst_trunc", 32'(frames_truncated), 32'd0);
        check("rst_ready_valid", {29'd0, m_valid, s0_ready, s1_ready}, 32'd0);
        reset = 1'b0;

        // Single 64-byte frame from s0.
        grant_log.delete();
        send_frame(0, 64, 1'b0);
        wait_done(2000, "single_done");
        check_counts("single");
        check("single_nframes", 32'(grant_log.size()), 32'd1);
        if (grant_log.size() > 0) check("single_grant", 32'(grant_log[0]), 32'(2'b01));

        // Both requesters continuously valid.
        do_reset();
        grant_log.delete();
        send_frame(0, 60, 1'b1);
        send_frame(0, 60, 1'b1);
        send_frame(1, 60, 1'b1);
        send_frame(1, 60, 1'b1);
        wait_done(4000, "rr_done");
        check_counts("rr");
        check("rr_nframes", 32'(grant_log.size()), 32'd4);
        for (int i = 0; i < 4 && i < grant_log.size(); i++) begin
            check("rr_seq", 32'(grant_log[i]), 32'(seq[i]));
        end

        // Oversize frame truncated, then exact-length frame.
        send_frame(1, 150, 1'b1);
        wait_done(3000, "trunc_done");
        check_counts("trunc");
        send_frame(0, 100, 1'b0);
        wait_done(3000, "exact_done");
        check_counts("exact");

        // Random backpressure.
        rand_ready = 1'b1;
        send_frame(0, 64, 1'b1);
        wait_done(4000, "bp_done");
        check_counts("bp");
        rand_ready = 1'b0;

        // Reset in the middle of a frame.
        base = beat_cnt;
        send_frame(0, 64, 1'b0);
        n = 0;
        while (beat_cnt - base < 30 && n < 2000) begin
            @(negedge clock125);
            #2;
            n++;
        end
        check("midrst_reach", 32'(n >= 2000), 32'd0);
        reset = 1'b1;
        exp0.delete();
        exp1.delete();
        model_sent  = 0;
        model_trunc = 0;
        @(posedge clock125);
        @(negedge clock125);
        #2;
        check("midrst_grant", 32'(grant), 32'd0);
        check("midrst_sent", 32'(frames_sent), 32'd0);
        check("midrst_trunc", 32'(frames_truncated), 32'd0);
        check("midrst_mvalid", 32'(m_valid), 32'd0);
        reset = 1'b0;
        send_frame(0, 64, 1'b0);
        wait_done(2000, "midrst_done");
        check_counts("midrst");

        // Random traffic on both requesters.
        bubbles    = 1'b1;
        rand_ready = 1'b1;
        for (int i = 0; i < 24; i++) begin
            send_frame(int'($urandom_range(0, 1)), int'($urandom_range(1, 150)), 1'b1);
        end
        wait_done(30000, "rand_done");
        check_counts("rand");
        bubbles    = 1'b0;
        rand_ready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
